ysyx_25020037_ifu_fetch: RTL

- Instruction fetch unit; the producing end of the IFU->IDU valid/ready interface.
- Issues single-beat AXI4-Lite read requests for the current PC, then presents {pc, inst} on fu_to_du_bus with ifu_valid until the IDU accepts it.
- Owns the architectural fetch PC: advances by 4 on handoff, reloads from exu_dnpc on an EXU redirect, and discards any in-flight response that has become stale.

---
 rtl/ysyx_25020037_ifu_fetch_pkg.sv | 26 ++
 rtl/ysyx_25020037_ifu_fetch_if.sv | 39 +++
 rtl/ysyx_25020037_ifu_fetch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_ifu_fetch_pkg
// Shared configuration for the instruction fetch unit and its interface:
//   FU_TO_DU_BUS_WD  - width of the IFU->IDU payload {pc, inst}
//   RESET_PC_DEFAULT - default first fetch address after reset
//   AXI_RESP_OKAY    - AXI4-Lite OKAY response code
//   fu_to_du_t       - packed view of the IFU->IDU payload
//   is_resp_err()    - true for any response other than OKAY
// ---------------------------------------------------------------------------
package ysyx_25020037_ifu_fetch_pkg;

    localparam int          FU_TO_DU_BUS_WD  = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;

    // pc sits in the upper half so the bus reads {pc, inst}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fu_to_du_t;

    function automatic logic is_resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_25020037_ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_ifu_fetch_if
// Bundles every handshake/bus signal of the fetch unit:
//   IFU->IDU : idu_ready, ifu_valid, fu_to_du_bus, fetch_err
//   EXU      : exu_dnpc_valid, exu_dnpc (redirect)
//   AXI4-Lite read channel : araddr, arvalid, arready, rdata, rresp,
//                            rvalid, rready
// Modports:
//   master - the fetch unit's view
//   slave  - the environment's view (IDU, EXU and memory side)
// ---------------------------------------------------------------------------
interface ysyx_25020037_ifu_fetch_if;
    import ysyx_25020037_ifu_fetch_pkg::*;

    logic                       idu_ready;
    logic                       ifu_valid;
    logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus;
    logic                       fetch_err;
    logic                       exu_dnpc_valid;
    logic [31:0]                exu_dnpc;
    logic [31:0]                araddr;
    logic                       arvalid;
    logic                       arready;
    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        input  idu_ready, exu_dnpc_valid, exu_dnpc, arready, rdata, rresp, rvalid,
        output ifu_valid, fu_to_du_bus, fetch_err, araddr, arvalid, rready
    );

    modport slave (
        output idu_ready, exu_dnpc_valid, exu_dnpc, arready, rdata, rresp, rvalid,
        input  ifu_valid, fu_to_du_bus, fetch_err, araddr, arvalid, rready
    );

endinterface

// File: rtl/ysyx_25020037_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_ifu_fetch
// Instruction fetch unit. Issues one single-beat AXI4-Lite read for the
// current PC, then offers {pc, inst} to the IDU until it is accepted.
// Owns the fetch PC: +4 on handoff, reload on EXU redirect, and drops any
// response that a redirect has made stale.
// Ports:
//   clk      - core clock
//   rst_n    - asynchronous active-low reset
//   fetch_if - master side of ysyx_25020037_ifu_fetch_if (IDU handoff,
//              EXU redirect, AXI read channel, fetch_err pulse)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ysyx_25020037_ifu_fetch
    import ysyx_25020037_ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_25020037_ifu_fetch_if.master     fetch_if
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] redir_pc_q,  redir_pc_d;
    logic        stale_q,     stale_d;
    logic        arvalid_q,   arvalid_d;
    logic        rready_q,    rready_d;
    logic        ifu_valid_q, ifu_valid_d;
    logic        fetch_err_q, fetch_err_d;
    fu_to_du_t   bus_q,       bus_d;

    logic redirect;
    logic transfer;

    assign redirect = fetch_if.exu_dnpc_valid;
    assign transfer = ifu_valid_q & fetch_if.idu_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        stale_d     = stale_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ifu_valid_d = ifu_valid_q;
        bus_d       = bus_q;
        fetch_err_d = 1'b0;          // single-cycle pulse by construction

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = fetch_if.exu_dnpc;
                end
                arvalid_d = 1'b1;
                state_d   = AR;
            end

            AR: begin
                // araddr is pc_q, which is never written here, so the
                // address stays stable while arvalid is high even when a
                // redirect arrives; the redirect is parked in redir_pc.
                if (redirect) begin
                    stale_d    = 1'b1;
                    redir_pc_d = fetch_if.exu_dnpc;
                end
                if (fetch_if.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end

            R: begin
                if (fetch_if.rvalid) begin
                    rready_d = 1'b0;
                    if (stale_q || redirect) begin
                        // Response belongs to an abandoned path: drop it.
                        // A redirect arriving this very cycle is newer
                        // than anything parked in redir_pc.
                        pc_d      = redirect ? fetch_if.exu_dnpc : redir_pc_q;
                        stale_d   = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end else begin
                        bus_d.pc    = pc_q;
                        bus_d.inst  = fetch_if.rdata;
                        ifu_valid_d = 1'b1;
                        fetch_err_d = is_resp_err(fetch_if.rresp);
                        state_d     = HOLD;
                    end
                end else if (redirect) begin
                    stale_d    = 1'b1;
                    redir_pc_d = fetch_if.exu_dnpc;
                end
            end

            HOLD: begin
                // Redirect beats a simultaneous transfer; the IDU squashes
                // its own copy on the same strobe.
                if (redirect) begin
                    ifu_valid_d = 1'b0;
                    pc_d        = fetch_if.exu_dnpc;
                    arvalid_d   = 1'b1;
                    state_d     = AR;
                end else if (transfer) begin
                    ifu_valid_d = 1'b0;
                    pc_d        = pc_q + 32'd4;
                    arvalid_d   = 1'b1;
                    state_d     = AR;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            redir_pc_q  <= 32'd0;
            stale_q     <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ifu_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            stale_q     <= stale_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ifu_valid_q <= ifu_valid_d;
            fetch_err_q <= fetch_err_d;
            bus_q       <= bus_d;
        end
    end

    assign fetch_if.araddr       = pc_q;
    assign fetch_if.arvalid      = arvalid_q;
    assign fetch_if.rready       = rready_q;
    assign fetch_if.ifu_valid    = ifu_valid_q;
    assign fetch_if.fu_to_du_bus = bus_q;
    assign fetch_if.fetch_err    = fetch_err_q;

endmodule
